// File: rtl/demm_pkg.sv
// Shared types and helpers for the DEMM tile read-request scheduler.
package demm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_B,
        ISSUE_A,
        DRAIN,
        DONE
    } demm_state_t;

    // Field widths match the default controller configuration.
    localparam int REQ_ADDR_W  = 64;
    localparam int REQ_BYTES_W = 13;
    localparam int REQ_LANE_W  = 2;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0]  addr;
        logic [REQ_BYTES_W-1:0] bytes;
        logic [REQ_LANE_W-1:0]  lane;
        logic                   is_b;
    } demm_req_t;

    // Bytes from addr up to the next burst-aligned boundary; burst is a power of 2.
    function automatic logic [31:0] burst_room(input logic [63:0] addr, input int unsigned burst);
        logic [63:0] mask;
        mask = 64'(burst) - 64'd1;
        return 32'(64'(burst) - (addr & mask));
    endfunction

endpackage

// File: rtl/demm_burst_splitter.sv
// Walks one contiguous byte region as bursts that never cross a MAX_BURST_BYTES boundary.
module demm_burst_splitter
    import demm_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 33,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int BYTES_W         = 13
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic [ADDR_W-1:0]  base,
    input  logic [LEN_W-1:0]   len,
    input  logic               adv,
    output logic [ADDR_W-1:0]  chunk_addr,
    output logic [BYTES_W-1:0] chunk_bytes,
    output logic               last,
    output logic               avail
);

    localparam int CMP_W = (LEN_W > 32) ? LEN_W : 32;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] eff_addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  eff_rem;
    logic [CMP_W-1:0]  room;
    logic [CMP_W-1:0]  rem_w;
    logic [CMP_W-1:0]  chunk;

    // A load presents the new region in the same cycle so rows follow back to back.
    always_comb begin
        eff_addr    = load ? base : cur_addr;
        eff_rem     = load ? len  : remaining;
        room        = CMP_W'(burst_room(64'(eff_addr), MAX_BURST_BYTES));
        rem_w       = CMP_W'(eff_rem);
        chunk       = (rem_w < room) ? rem_w : room;
        last        = (rem_w <= room);
        chunk_addr  = eff_addr;
        chunk_bytes = BYTES_W'(chunk);
        avail       = load || (remaining != '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            remaining <= '0;
        end else if (load || adv) begin
            remaining <= eff_rem - (adv ? LEN_W'(chunk) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (load || adv) begin
            cur_addr <= eff_addr + (adv ? ADDR_W'(chunk) : '0);
        end
    end

endmodule

// File: rtl/demm_tile_issue_ctrl.sv
// DEMM read-request scheduler: streams B once, then each A row round-robin over lanes,
// split at burst boundaries and throttled by an outstanding-request credit counter.
module demm_tile_issue_ctrl
    import demm_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int ADDR_W          = 64,
    parameter int DIM_W           = 16,
    parameter int ELEM_BYTES      = 2,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [DIM_W-1:0]                     m_num,
    input  logic [DIM_W-1:0]                     n_num,
    input  logic [DIM_W-1:0]                     k_num,
    input  logic [ADDR_W-1:0]                    a_base,
    input  logic [ADDR_W-1:0]                    b_base,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic                                 req_valid,
    input  logic                                 req_ready,
    output logic [ADDR_W-1:0]                    req_addr,
    output logic [$clog2(MAX_BURST_BYTES):0]     req_bytes,
    output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] req_lane,
    output logic                                 req_is_b,
    input  logic                                 cpl_valid
);

    localparam int BYTES_W = $clog2(MAX_BURST_BYTES) + 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ELEM_SH = $clog2(ELEM_BYTES);
    localparam int LEN_W   = 2 * DIM_W + ELEM_SH;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    demm_state_t state, state_nxt;

    logic [DIM_W-1:0]   cfg_m, cfg_n, cfg_k;
    logic [ADDR_W-1:0]  cfg_b, row_addr;
    logic [DIM_W-1:0]   row_cnt;
    logic [LANE_W-1:0]  lane_cnt;
    logic               need_load;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               vld;
    demm_req_t          req_q, req_d;

    logic               start_acc, zero_dim, hs, cpl_eff, spurious, issuing, last_row;
    logic               sp_load, sp_avail, sp_last, cap;
    logic [LEN_W-1:0]   b_len, row_len, sp_len;
    logic [ADDR_W-1:0]  sp_base, sp_addr;
    logic [BYTES_W-1:0] sp_bytes;

    always_comb begin
        start_acc = start && ((state == IDLE) || (state == DONE));
        zero_dim  = (m_num == '0) || (n_num == '0) || (k_num == '0);
        hs        = vld && req_ready;
        cpl_eff   = cpl_valid && (cnt != '0);
        spurious  = cpl_valid && (cnt == '0);
        cnt_nxt   = cnt + CNT_W'(hs) - CNT_W'(cpl_eff);
        issuing   = (state == ISSUE_B) || (state == ISSUE_A);
        last_row  = (row_cnt == cfg_m - DIM_W'(1));
        sp_load   = issuing && need_load;
        // A new request is captured only if the credit count after this edge leaves room.
        cap       = issuing && sp_avail && (!vld || hs) && (cnt_nxt != CNT_W'(MAX_OUTSTANDING));
        b_len     = (LEN_W'(cfg_k) * LEN_W'(cfg_n)) << ELEM_SH;
        row_len   = LEN_W'(cfg_k) << ELEM_SH;
        sp_base   = (state == ISSUE_B) ? cfg_b : row_addr;
        sp_len    = (state == ISSUE_B) ? b_len : row_len;
    end

    demm_burst_splitter #(
        .ADDR_W          (ADDR_W),
        .LEN_W           (LEN_W),
        .MAX_BURST_BYTES (MAX_BURST_BYTES),
        .BYTES_W         (BYTES_W)
    ) u_splitter (
        .clk         (clk),
        .rstn        (rstn),
        .load        (sp_load),
        .base        (sp_base),
        .len         (sp_len),
        .adv         (cap),
        .chunk_addr  (sp_addr),
        .chunk_bytes (sp_bytes),
        .last        (sp_last),
        .avail       (sp_avail)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc) state_nxt = zero_dim ? DONE : ISSUE_B;
            end
            ISSUE_B: begin
                busy = 1'b1;
                if (cap && sp_last) state_nxt = ISSUE_A;
            end
            ISSUE_A: begin
                busy = 1'b1;
                if (cap && sp_last && last_row) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((cnt == '0) && !vld) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_acc) state_nxt = zero_dim ? DONE : ISSUE_B;
                else           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            vld       <= 1'b0;
            error     <= 1'b0;
            need_load <= 1'b0;
            row_cnt   <= '0;
            lane_cnt  <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (cap)     vld <= 1'b1;
            else if (hs) vld <= 1'b0;
            if (start_acc)     error <= zero_dim || spurious;
            else if (spurious) error <= 1'b1;
            if (start_acc) begin
                need_load <= !zero_dim;
                row_cnt   <= '0;
                lane_cnt  <= '0;
            end else begin
                if (sp_load) need_load <= 1'b0;
                if (cap && sp_last) begin
                    if (state == ISSUE_B) begin
                        need_load <= 1'b1;
                    end else if (!last_row) begin
                        need_load <= 1'b1;
                        row_cnt   <= row_cnt + DIM_W'(1);
                        lane_cnt  <= (lane_cnt == LANE_W'(LANES - 1)) ? '0 : lane_cnt + LANE_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        req_d.addr  = REQ_ADDR_W'(sp_addr);
        req_d.bytes = REQ_BYTES_W'(sp_bytes);
        req_d.lane  = (state == ISSUE_B) ? '0 : REQ_LANE_W'(lane_cnt);
        req_d.is_b  = (state == ISSUE_B);
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            cfg_m    <= m_num;
            cfg_n    <= n_num;
            cfg_k    <= k_num;
            cfg_b    <= b_base;
            row_addr <= a_base;
        end else if (cap && sp_last && (state == ISSUE_A)) begin
            row_addr <= row_addr + ADDR_W'(row_len);
        end
        if (cap) req_q <= req_d;
    end

    always_comb begin
        req_valid = vld;
        req_addr  = ADDR_W'(req_q.addr);
        req_bytes = BYTES_W'(req_q.bytes);
        req_lane  = LANE_W'(req_q.lane);
        req_is_b  = req_q.is_b;
    end

endmodule

// File: tb/tb_demm_tile_issue_ctrl.sv
// Scoreboard bench for demm_tile_issue_ctrl: expected bursts queued at job start, popped on handshake.
module tb_demm_tile_issue_ctrl;

    localparam int LANES = 4;
    localparam int ELEM  = 2;
    localparam int MAXB  = 4096;
    localparam int MAXO  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] m_num = '0, n_num = '0, k_num = '0;
    logic [63:0] a_base = '0, b_base = '0;
    logic        busy, done, error;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic [12:0] req_bytes;
    logic [1:0]  req_lane;
    logic        req_is_b;
    logic        cpl_valid = 1'b0;

    always #5 clk = ~clk;

    demm_tile_issue_ctrl #(
        .LANES           (LANES),
        .ADDR_W          (64),
        .DIM_W           (16),
        .ELEM_BYTES      (ELEM),
        .MAX_BURST_BYTES (MAXB),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .m_num     (m_num),
        .n_num     (n_num),
        .k_num     (k_num),
        .a_base    (a_base),
        .b_base    (b_base),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_bytes (req_bytes),
        .req_lane  (req_lane),
        .req_is_b  (req_is_b),
        .cpl_valid (cpl_valid)
    );

    typedef struct {
        logic [63:0] addr;
        logic [12:0] bytes;
        logic [1:0]  lane;
        logic        is_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   hs_count = 0, cpl_sent = 0, done_seen = 0;

    // Handshake monitor: pops the scoreboard and checks fields hold while stalled.
    initial begin : monitor
        logic        stall_prev;
        logic [63:0] p_addr;
        logic [12:0] p_bytes;
        logic [1:0]  p_lane;
        logic        p_isb;
        exp_t        e;
        stall_prev = 1'b0;
        p_addr = '0; p_bytes = '0; p_lane = '0; p_isb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (req_valid !== 1'b1 || req_addr !== p_addr || req_bytes !== p_bytes ||
                        req_lane !== p_lane || req_is_b !== p_isb) begin
                        errors++;
                        $display("FAIL hold_stable got v=%b addr=%h bytes=%0d lane=%0d b=%b want v=1 addr=%h bytes=%0d lane=%0d b=%b",
                                 req_valid, req_addr, req_bytes, req_lane, req_is_b, p_addr, p_bytes, p_lane, p_isb);
                    end
                end
                if (req_valid === 1'b1 && req_ready === 1'b1) begin
                    hs_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_seq got addr=%h bytes=%0d lane=%0d b=%b want no request",
                                 req_addr, req_bytes, req_lane, req_is_b);
                    end else begin
                        e = exp_q.pop_front();
                        if (req_addr !== e.addr || req_bytes !== e.bytes || req_lane !== e.lane || req_is_b !== e.is_b) begin
                            errors++;
                            $display("FAIL req_seq got addr=%h bytes=%0d lane=%0d b=%b want addr=%h bytes=%0d lane=%0d b=%b",
                                     req_addr, req_bytes, req_lane, req_is_b, e.addr, e.bytes, e.lane, e.is_b);
                        end
                    end
                end
                stall_prev = (req_valid === 1'b1) && (req_ready !== 1'b1);
                p_addr = req_addr; p_bytes = req_bytes; p_lane = req_lane; p_isb = req_is_b;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic push_region(input logic [63:0] addr, input longint len, input int lane, input logic isb);
        longint room, ch;
        exp_t   e;
        while (len > 0) begin
            room = longint'(MAXB) - longint'(addr % 64'(MAXB));
            ch   = (len < room) ? len : room;
            e.addr = addr; e.bytes = 13'(ch); e.lane = 2'(lane); e.is_b = isb;
            exp_q.push_back(e);
            addr = addr + 64'(ch);
            len  = len - ch;
        end
    endtask

    task automatic start_job(input int m, input int n, input int k, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        m_num = 16'(m); n_num = 16'(n); k_num = 16'(k);
        a_base = a; b_base = b;
        start = 1'b1;
        if (m != 0 && n != 0 && k != 0) begin
            push_region(b, longint'(k) * n * ELEM, 0, 1'b1);
            for (int r = 0; r < m; r++)
                push_region(a + 64'(r * k * ELEM), longint'(k) * ELEM, r % LANES, 1'b0);
        end
    endtask

    // cpl_mode: 0 none, 1 one pulse, 2 complete the oldest outstanding request.
    task automatic cycle(input logic rdy, input int cpl_mode);
        logic c;
        @(posedge clk); #1;
        if (done === 1'b1) done_seen++;
        c = (cpl_mode == 1) || (cpl_mode == 2 && cpl_sent < hs_count);
        start = 1'b0;
        req_ready = rdy;
        cpl_valid = c;
        if (c) cpl_sent++;
    endtask

    task automatic run_to_done(input int budget, input logic rand_rdy, output int ndone);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget; i++) begin
            cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 2);
            if (done_seen != d0) break;
        end
        repeat (3) cycle(1'b1, 2);
        ndone = done_seen - d0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0)     begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", req_valid); end
        rstn = 1'b1;
    endtask

    task automatic test_nominal();
        int nd;
        start_job(4, 8, 16, 64'h1000_0000, 64'h0);
        cycle(1'b1, 2);
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL nom_busy got %b want 1", busy); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL nom_early_valid got %b want 0", req_valid); end
        cycle(1'b1, 2);
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL nom_latency got %b want 1", req_valid); end
        run_to_done(200, 1'b0, nd);
        checks++; if (nd != 1)            begin errors++; $display("FAIL nom_done got %0d want 1", nd); end
        checks++; if (error !== 1'b0)     begin errors++; $display("FAIL nom_error got %b want 0", error); end
        checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL nom_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_boundary();
        int nd;
        start_job(1, 16, 16, 64'h2000, 64'hF80);
        run_to_done(200, 1'b0, nd);
        checks++; if (nd != 1)           begin errors++; $display("FAIL bnd_done got %0d want 1", nd); end
        checks++; if (error !== 1'b0)    begin errors++; $display("FAIL bnd_error got %b want 0", error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bnd_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_zero_dim();
        int   d0;
        logic any_v;
        d0 = done_seen;
        any_v = 1'b0;
        start_job(4, 8, 0, 64'h1000, 64'h2000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 0);
            if (req_valid !== 1'b0) any_v = 1'b1;
        end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_seen - d0); end
        checks++; if (any_v !== 1'b0)      begin errors++; $display("FAIL zero_valid got %b want 0", any_v); end
        checks++; if (error !== 1'b1)      begin errors++; $display("FAIL zero_error got %b want 1", error); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int nd;
        start_job(5, 8, 40, 64'hFF0, 64'h3F00);
        run_to_done(2000, 1'b1, nd);
        checks++; if (nd != 1)           begin errors++; $display("FAIL bp_done got %0d want 1", nd); end
        checks++; if (error !== 1'b0)    begin errors++; $display("FAIL bp_error got %b want 0", error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_spurious_cpl();
        @(posedge clk); #1;
        cpl_valid = 1'b1;
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL spur_error got %b want 1", error); end
    endtask

    task automatic test_credit_stall();
        int h0, nd;
        start_job(16, 8, 16, 64'h5000, 64'h4000);
        h0 = hs_count;
        repeat (40) cycle(1'b1, 0);
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL cred_err_clr got %b want 0", error); end
        checks++; if (hs_count - h0 != 8)  begin errors++; $display("FAIL cred_stall got %0d want 8", hs_count - h0); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL cred_valid got %b want 0", req_valid); end
        cycle(1'b1, 1);
        repeat (6) cycle(1'b1, 0);
        checks++; if (hs_count - h0 != 9)  begin errors++; $display("FAIL cred_one got %0d want 9", hs_count - h0); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL cred_one_valid got %b want 0", req_valid); end
        cycle(1'b1, 1);
        cycle(1'b1, 1);
        repeat (6) cycle(1'b1, 0);
        checks++; if (hs_count - h0 != 11) begin errors++; $display("FAIL cred_simul got %0d want 11", hs_count - h0); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL cred_simul_valid got %b want 0", req_valid); end
        run_to_done(400, 1'b0, nd);
        checks++; if (nd != 1)             begin errors++; $display("FAIL cred_done got %0d want 1", nd); end
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL cred_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midjob();
        logic found;
        int   d0, nd;
        found = 1'b0;
        start_job(8, 8, 16, 64'h6000, 64'h7000);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 2);
            if (req_valid === 1'b1 && req_is_b === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_a got %b want 1", found); end
        d0 = done_seen;
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", req_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b want 0", done); end
        rstn = 1'b1;
        cpl_valid = 1'b0;
        exp_q.delete();
        cpl_sent = hs_count;
        repeat (4) cycle(1'b1, 0);
        checks++; if (done_seen != d0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_seen - d0); end
        start_job(4, 8, 16, 64'h1000_0000, 64'h0);
        run_to_done(200, 1'b0, nd);
        checks++; if (nd != 1)           begin errors++; $display("FAIL rst_rerun_done got %0d want 1", nd); end
        checks++; if (error !== 1'b0)    begin errors++; $display("FAIL rst_rerun_error got %b want 0", error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_rerun_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundary();
        test_zero_dim();
        test_backpressure();
        test_spurious_cpl();
        test_credit_stall();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demm_tile_issue_ctrl.md
Name: demm_tile_issue_ctrl

Overview:
Parametrised read-request scheduler for the DEMM calc kernel. It replaces fixed per-matrix DMA issue with one controller. Per job it streams the full B matrix once, then every A row, round-robin over LANES compute lanes. Each contiguous region is split into bursts that never cross a MAX_BURST_BYTES boundary, and in-flight requests are bounded by a credit counter. It sits between the kernel control registers and the AXI read DMA front-end.

Parameters:
LANES, 4, number of compute lanes; A rows are assigned round-robin to lanes.
ADDR_W, 64, byte address width.
DIM_W, 16, width of the M/N/K dimension inputs.
ELEM_BYTES, 2, bytes per matrix element; must be a power of 2.
MAX_BURST_BYTES, 4096, burst boundary and maximum burst size; must be a power of 2 and at least ELEM_BYTES.
MAX_OUTSTANDING, 8, maximum number of requests issued but not yet completed.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle job start pulse; ignored while busy=1
m_num  in  DIM_W  rows of A
n_num  in  DIM_W  columns of B
k_num  in  DIM_W  columns of A and rows of B
a_base  in  ADDR_W  byte base address of A (row-major)
b_base  in  ADDR_W  byte base address of B (row-major)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end
error  out  1  sticky; cleared by the next accepted start
req_valid  out  1  request valid
req_ready  in  1  downstream accept
req_addr  out  ADDR_W  burst start byte address
req_bytes  out  $clog2(MAX_BURST_BYTES)+1  burst length in bytes; always >0
req_lane  out  $clog2(LANES) (min 1)  target lane; 0 for B requests
req_is_b  out  1  1 = B-matrix request
cpl_valid  in  1  one completed request, one pulse per request

Behaviour:
- Reset values: busy=0, done=0, error=0, req_valid=0, outstanding counter=0, state=IDLE. Reset mid-job aborts the job immediately and no done pulse is produced.
- Config latch: m/n/k/a_base/b_base are latched on an accepted start and are not sampled again during the job.
- Zero dimension: if any of m, n, k is 0, go IDLE->DONE. No requests are issued and error is set.
- State machine: IDLE -> ISSUE_B -> ISSUE_A -> DRAIN -> DONE -> IDLE.
  - ISSUE_B region: b_base, length K*N*ELEM_BYTES.
  - ISSUE_A regions: row r at a_base + r*K*ELEM_BYTES, length K*ELEM_BYTES, lane = r mod LANES, for r = 0..M-1.
- Region arithmetic: computed at width 2*DIM_W + $clog2(ELEM_BYTES), with no truncation.
- Burst splitting: chunk = min(remaining, MAX_BURST_BYTES - (addr mod MAX_BURST_BYTES)). After each handshake, addr += chunk and remaining -= chunk. The region ends when remaining = 0.
- Handshake:
  - req_* outputs are registered.
  - Once req_valid=1, all req_* fields hold stable until req_valid & req_ready.
  - After a handshake, the next request may be presented the following cycle, giving 1 request/cycle throughput.
- Credits:
  - The counter increments on a handshake and decrements on cpl_valid; both in the same cycle leaves it unchanged.
  - req_valid is not raised while the counter equals MAX_OUTSTANDING.
  - cpl_valid with the counter at 0 is ignored and sets error.
- DRAIN: waits for the counter to reach 0. Then DONE pulses done=1 for one cycle, busy drops in the same cycle, and the state returns to IDLE.
- Latency: the first req_valid is asserted 2 cycles after the start pulse.

Decomposition:
- Package demm_pkg holds:
  - the state enum (IDLE, ISSUE_B, ISSUE_A, DRAIN, DONE);
  - a request struct {addr, bytes, lane, is_b};
  - a function computing the distance from an address to the next burst boundary.
- One sub-module, demm_burst_splitter:
  - inputs: region base, length, load;
  - outputs: chunk addr/bytes and last;
  - behaviour: advances on handshake.
- The top level holds the FSM, row/lane counters and the credit counter.

Test Plan:
- Nominal job: M=4, N=8, K=16, ELEM=2, b_base=0, a_base=0x1000_0000, ready=1, immediate cpl.
  - Expect one B request of 256 bytes.
  - Then 4 A requests of 32 bytes at 0x1000_0000 + r*32, with lanes 0,1,2,3.
  - done pulses once; error=0.
- Boundary split: b_base=0xF80, N*K*2=512.
  - Expect B requests {0xF80, 128} then {0x1000, 384}.
- Credit stall: MAX_OUTSTANDING=8, M=16, no cpl.
  - Exactly 8 handshakes, then req_valid stays 0.
  - Each single cpl_valid pulse releases exactly one more request.
  - A simultaneous cpl and handshake keeps the count at 8.
- Backpressure: req_ready toggles randomly.
  - req_addr/bytes/lane are stable while valid and not ready.
  - Request sequence is identical to the ready=1 run.
- Zero dimension / spurious completion:
  - k_num=0 -> done within 3 cycles, no req_valid, error=1.
  - cpl_valid while idle -> error=1, counter remains 0.
- Reset mid-job: rstn low during ISSUE_A.
  - Next cycle: req_valid=0, busy=0, no done pulse.
  - A new start afterwards runs a full correct job.
